// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: operation codes and FSM
// state encoding. Imported by iter_shifter and shift_step.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_LD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational next-value shifter for iter_shifter.
// Build option: SHIFT4_EN adds the 4-position path (selected by i_step4).
// Ports:
//   i_q     current result word
//   i_op    operation (SLL/SRL/SRA; LD passes i_q through)
//   i_step4 select the 4-position path (ignored without SHIFT4_EN)
//   o_q     shifted word
module shift_step
    import shift_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] i_q,
    input  logic [1:0]      i_op,
    input  logic            i_step4,
    output logic [SIZE-1:0] o_q
);

    logic [SIZE-1:0] w_step1;

    always_comb begin
        w_step1 = i_q;
        case (i_op)
            OP_SLL:  w_step1 = i_q << 1;
            OP_SRL:  w_step1 = i_q >> 1;
            OP_SRA:  w_step1 = $unsigned($signed(i_q) >>> 1);
            default: w_step1 = i_q;
        endcase
    end

`ifdef SHIFT4_EN
    logic [SIZE-1:0] w_step4;

    always_comb begin
        w_step4 = i_q;
        case (i_op)
            OP_SLL:  w_step4 = i_q << 4;
            OP_SRL:  w_step4 = i_q >> 4;
            OP_SRA:  w_step4 = $unsigned($signed(i_q) >>> 4);
            default: w_step4 = i_q;
        endcase
    end

    assign o_q = i_step4 ? w_step4 : w_step1;
`else
    // Select input kept on the port so the interface is build-independent.
    logic w_unused_step4;
    assign w_unused_step4 = i_step4;
    assign o_q = w_step1;
`endif

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: iterative SLL/SRL/SRA unit, one position per clock
// (four per clock while count>=4 when built with SHIFT4_EN), with a
// start/busy/done handshake.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       request, sampled only when not busy
//   op          00 SLL, 01 SRL, 10 SRA, 11 LD (load dt unchanged)
//   dt, amt     operand and shift amount, sampled with an accepted start
//   Q           result register
//   busy        high while shifting
//   done        one-cycle pulse, Q holds the final result
module iter_shifter
    import shift_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int AMT_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SIZE-1:0]  dt,
    input  logic [AMT_W-1:0] amt,
    output logic [SIZE-1:0]  Q,
    output logic             busy,
    output logic             done
);

    state_t           r_state, w_state_nxt;
    logic [SIZE-1:0]  r_q, w_q_nxt, w_shifted;
    logic [AMT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_dec;
    logic [1:0]       r_op, w_op_nxt;
    logic             w_step4;

`ifdef SHIFT4_EN
    // Widen before comparing so narrow counters cannot wrap the constant.
    assign w_step4   = (32'(r_cnt) >= 32'd4);
    assign w_cnt_dec = w_step4 ? (r_cnt - AMT_W'(4)) : (r_cnt - AMT_W'(1));
`else
    assign w_step4   = 1'b0;
    assign w_cnt_dec = r_cnt - AMT_W'(1);
`endif

    shift_step #(.SIZE(SIZE)) u_step (
        .i_q    (r_q),
        .i_op   (r_op),
        .i_step4(w_step4),
        .o_q    (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_op    <= OP_SLL;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            ST_SHIFT: begin
                w_q_nxt   = w_shifted;
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_dec == '0)
                    w_state_nxt = ST_DONE;
            end
            // IDLE, DONE (and the unused encoding) accept a new request;
            // taking start in DONE gives back-to-back operation.
            default: begin
                if (start) begin
                    w_q_nxt     = dt;
                    w_cnt_nxt   = amt;
                    w_op_nxt    = op;
                    w_state_nxt = (amt == '0 || op == OP_LD) ? ST_DONE : ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    assign Q    = r_q;
    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

    localparam int SIZE  = 8;
    localparam int AMT_W = 3;

`ifdef SHIFT4_EN
    localparam int S_AMT4 = 1;  // amt=4
    localparam int S_AMT6 = 3;  // amt=6 (4,1,1)
    localparam int S_AMT7 = 4;  // amt=7 (4,1,1,1)
`else
    localparam int S_AMT4 = 4;
    localparam int S_AMT6 = 6;
    localparam int S_AMT7 = 7;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [SIZE-1:0]  dt = '0;
    logic [AMT_W-1:0] amt = '0;
    logic [SIZE-1:0]  Q;
    logic             busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    iter_shifter #(.SIZE(SIZE)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .dt   (dt),
        .amt  (amt),
        .Q    (Q),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; sample and drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request: Q=dt after E, busy for S cycles, done with Q=expq after E+S,
    // done gone one edge later with Q held.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] d,
                          input logic [2:0] a, input logic [7:0] expq, input int s);
        start = 1'b1; op = o; dt = d; amt = a;
        tick();
        start = 1'b0;
        chk({tag, " Q=dt"}, 32'(Q), 32'(d));
        for (int k = 0; k < s; k++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " no done"}, 32'(done), 32'd0);
            tick();
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " idle at done"}, 32'(busy), 32'd0);
        chk({tag, " result"}, 32'(Q), 32'(expq));
        tick();
        chk({tag, " done drops"}, 32'(done), 32'd0);
        chk({tag, " Q holds"}, 32'(Q), 32'(expq));
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("reset Q", 32'(Q), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // Directed vectors
        run_op("sll3",  2'b00, 8'h03, 3'd3, 8'h18, 3);
        run_op("srl2",  2'b01, 8'h90, 3'd2, 8'h24, 2);
        run_op("sra2",  2'b10, 8'h90, 3'd2, 8'hE4, 2);
        run_op("sra7",  2'b10, 8'h70, 3'd7, 8'h00, S_AMT7);
        run_op("amt0",  2'b00, 8'hA5, 3'd0, 8'hA5, 0);
        run_op("ld5",   2'b11, 8'h3C, 3'd5, 8'h3C, 0);
        run_op("sll7",  2'b00, 8'h01, 3'd7, 8'h80, S_AMT7);
        run_op("sra1",  2'b10, 8'h81, 3'd1, 8'hC0, 1);

        // Start while busy is ignored: SLL 05 by 4 -> 50
        start = 1'b1; op = 2'b00; dt = 8'h05; amt = 3'd4;
        tick();                                   // E
        start = 1'b1; op = 2'b01; dt = 8'hFF; amt = 3'd1;
        tick();                                   // E+1, stray start
        start = 1'b0;
        chk("ign Q E+1", 32'(Q), (S_AMT4 == 1) ? 32'h50 : 32'h0A);
        for (int k = 1; k < S_AMT4; k++) tick();
        chk("ign done", 32'(done), 32'd1);
        chk("ign result", 32'(Q), 32'h50);

        // Back-to-back: start held during DONE is accepted (SRL 80 by 1)
        start = 1'b1; op = 2'b01; dt = 8'h80; amt = 3'd1;
        tick();
        start = 1'b0;
        chk("b2b done drops", 32'(done), 32'd0);
        chk("b2b busy", 32'(busy), 32'd1);
        chk("b2b Q=dt", 32'(Q), 32'h80);
        tick();
        chk("b2b done", 32'(done), 32'd1);
        chk("b2b result", 32'(Q), 32'h40);
        tick();
        chk("b2b done end", 32'(done), 32'd0);

        // Reset at E+2 of an amt=6 shift aborts
        start = 1'b1; op = 2'b00; dt = 8'h01; amt = 3'd6;
        tick();                                   // E
        start = 1'b0;
        tick();                                   // E+1
        chk("abort busy pre", 32'(busy), (S_AMT6 > 1) ? 32'd1 : 32'd0);
        reset = 1'b1;
        tick();                                   // E+2
        reset = 1'b0;
        chk("abort Q", 32'(Q), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort no done", 32'(done), 32'd0);
            chk("abort Q stays", 32'(Q), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
